// File: rtl/mem_io_responder_pkg.sv
// Shared address map and bus-cycle decode for the memory/I-O responder.
// Optional receive path is selected with the MEM_IO_RX_EN macro in the top.
package mem_io_responder_pkg;

  localparam logic [31:0] IO_BASE      = 32'h0003_0000;
  localparam logic [31:0] IO_DATA_ADDR = 32'h0003_0000;
  localparam logic [31:0] IO_HALT_ADDR = 32'h0003_0004;

  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_IO_DATA,
    SEL_IO_HALT,
    SEL_IO_OTHER
  } sel_e;

  // The whole 64 KiB page at IO_BASE belongs to I/O; everything else is RAM.
  function automatic sel_e mem_io_decode(input logic [31:0] addr);
    if (addr[31:16] != IO_BASE[31:16]) return SEL_RAM;
    if (addr == IO_DATA_ADDR)          return SEL_IO_DATA;
    if (addr == IO_HALT_ADDR)          return SEL_IO_HALT;
    return SEL_IO_OTHER;
  endfunction

endpackage

// File: rtl/mem_io_responder_sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes while full and pops while
// empty are ignored. Head reads as zero when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is deliberately left out of reset; pointers alone define
  // validity, and a reset port would prevent mapping onto RAM primitives.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder: byte RAM plus memory-mapped TX/RX FIFOs and halt port.
// Define MEM_IO_RX_EN to build the receive FIFO behind the data port.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_FIFO_DEPTH  = 8,
  parameter int RX_FIFO_DEPTH  = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mc_to_mem_addr,
  input  logic        mc_to_mem_wr,
  input  logic [7:0]  mc_to_mem_dout,
  output logic [7:0]  mem_to_mc_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_finish
);

  localparam int              TX_CW   = $clog2(TX_FIFO_DEPTH) + 1;
  localparam logic [TX_CW-1:0] TX_MARK = TX_CW'(TX_FIFO_DEPTH - 2);

  logic [7:0] ram [2**RAM_ADDR_WIDTH];

  sel_e                      sel;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;
  logic                      ram_wr;
  logic                      tx_push;
  logic                      rx_pop;
  logic                      halt_set;
  logic                      data_rd;
  logic                      tx_empty;
  logic                      tx_full;
  logic [TX_CW-1:0]          tx_count;
  logic [7:0]                rx_byte;

  assign sel     = mem_io_decode(mc_to_mem_addr);
  assign ram_idx = mc_to_mem_addr[RAM_ADDR_WIDTH-1:0];

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    ram_wr   = 1'b0;
    tx_push  = 1'b0;
    halt_set = 1'b0;
    data_rd  = 1'b0;
    if (rdy_in) begin
      unique case (sel)
        SEL_RAM:     ram_wr   = mc_to_mem_wr;
        SEL_IO_DATA: begin
          tx_push = mc_to_mem_wr;
          data_rd = !mc_to_mem_wr;
        end
        SEL_IO_HALT: halt_set = mc_to_mem_wr;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (ram_wr) ram[ram_idx] <= mc_to_mem_dout;
  end

  // Writes leave the read register untouched; only reads update it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_to_mc_din <= '0;
    end else if (rdy_in && !mc_to_mem_wr) begin
      unique case (sel)
        SEL_RAM:     mem_to_mc_din <= ram[ram_idx];
        SEL_IO_DATA: mem_to_mc_din <= rx_byte;
        default:     mem_to_mc_din <= '0;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)        program_finish <= 1'b0;
    else if (halt_set) program_finish <= 1'b1;
  end

  sync_fifo #(.WIDTH(8), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (tx_push),
    .din   (mc_to_mem_dout),
    .pop   (tx_valid && tx_ready),
    .dout  (tx_data),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign tx_valid = !tx_empty;
  // Two-entry margin absorbs the store already in flight after the check.
  assign io_buffer_full = (tx_count >= TX_MARK);

`ifdef MEM_IO_RX_EN
  logic                              rx_empty;
  logic                              rx_full;
  logic [7:0]                        rx_head;
  logic [$clog2(RX_FIFO_DEPTH):0]    rx_count;
  logic                              unused_rx;

  sync_fifo #(.WIDTH(8), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (rx_valid && rx_ready),
    .din   (rx_data),
    .pop   (rx_pop),
    .dout  (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign rx_ready  = !rx_full;
  assign rx_pop    = data_rd && !rx_empty;
  assign rx_byte   = rx_empty ? 8'h00 : rx_head;
  assign unused_rx = ^{rx_count, tx_full};
`else
  logic unused_rx;

  assign rx_ready  = 1'b0;
  assign rx_pop    = 1'b0;
  assign rx_byte   = 8'h00;
  assign unused_rx = ^{rx_data, rx_valid, rx_pop, data_rd, tx_full};
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder; the receive checks follow MEM_IO_RX_EN.
module tb_mem_io_responder;

  localparam logic [31:0] A_DATA  = 32'h0003_0000;
  localparam logic [31:0] A_HALT  = 32'h0003_0004;
  localparam logic [31:0] A_OTHER = 32'h0003_0008;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] mc_to_mem_addr;
  logic        mc_to_mem_wr;
  logic [7:0]  mc_to_mem_dout;
  logic [7:0]  mem_to_mc_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_finish;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mc_to_mem_addr (mc_to_mem_addr),
    .mc_to_mem_wr   (mc_to_mem_wr),
    .mc_to_mem_dout (mc_to_mem_dout),
    .mem_to_mc_din  (mem_to_mc_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .program_finish (program_finish)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus(input logic [31:0] a, input logic w, input logic [7:0] d);
    mc_to_mem_addr = a;
    mc_to_mem_wr   = w;
    mc_to_mem_dout = d;
    step();
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    mc_to_mem_addr = '0; mc_to_mem_wr = 1'b0; mc_to_mem_dout = '0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    step();
    step();
    rst_in = 1'b0;

    check("reset_din",    mem_to_mc_din,  8'h00);
    check("reset_full",   io_buffer_full, 1'b0);
    check("reset_txv",    tx_valid,       1'b0);
    check("reset_txd",    tx_data,        8'h00);
    check("reset_finish", program_finish, 1'b0);
`ifdef MEM_IO_RX_EN
    check("reset_rx_ready", rx_ready, 1'b1);
`else
    check("reset_rx_ready", rx_ready, 1'b0);
`endif

    // Write then read-back next cycle.
    bus(32'h0000_0100, 1'b1, 8'hA5);
    bus(32'h0000_0100, 1'b0, 8'h00);
    check("ram_wr_rd", mem_to_mc_din, 8'hA5);

    // Back-to-back reads, one edge latency each.
    bus(32'h0000_0200, 1'b1, 8'h11);
    bus(32'h0000_0201, 1'b1, 8'h22);
    bus(32'h0000_0202, 1'b1, 8'h33);
    bus(32'h0000_0203, 1'b1, 8'h44);
    bus(32'h0000_0200, 1'b0, 8'h00); check("burst0", mem_to_mc_din, 8'h11);
    bus(32'h0000_0201, 1'b0, 8'h00); check("burst1", mem_to_mc_din, 8'h22);
    bus(32'h0000_0202, 1'b0, 8'h00); check("burst2", mem_to_mc_din, 8'h33);
    bus(32'h0000_0203, 1'b0, 8'h00); check("burst3", mem_to_mc_din, 8'h44);

    // rdy_in low freezes the bus side.
    bus(32'h0000_0010, 1'b1, 8'h55);
    check("wr_holds_din", mem_to_mc_din, 8'h44);
    rdy_in = 1'b0;
    bus(32'h0000_0010, 1'b1, 8'h77);
    bus(A_DATA, 1'b1, 8'h12);
    check("rdy_no_tx_push", tx_valid, 1'b0);
    bus(32'h0000_0010, 1'b0, 8'h00);
    check("rdy_din_hold", mem_to_mc_din, 8'h44);
    rdy_in = 1'b1;
    bus(32'h0000_0010, 1'b0, 8'h00);
    check("rdy_no_ram_wr", mem_to_mc_din, 8'h55);

    // Fill TX with the sink stalled; the 9th byte must be dropped.
    for (int i = 0; i < 9; i++) begin
      bus(A_DATA, 1'b1, (i == 8) ? 8'hEE : 8'(8'hC0 + i));
      if (i == 4) check("full_after5", io_buffer_full, 1'b0);
      if (i == 5) check("full_after6", io_buffer_full, 1'b1);
    end
    mc_to_mem_addr = 32'h0000_0100;
    mc_to_mem_wr   = 1'b0;
    check("tx_head", tx_data, 8'hC0);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", tx_valid, 1'b1);
      check("drain_data",  tx_data,  8'(8'hC0 + i));
      step();
    end
    check("drain_empty", tx_valid, 1'b0);
    check("drain_full",  io_buffer_full, 1'b0);

    // Halt port is sticky; other I/O offsets read zero.
    bus(32'h0000_0100, 1'b0, 8'h00);
    bus(A_OTHER, 1'b0, 8'h00);
    check("io_other_rd", mem_to_mc_din, 8'h00);
    bus(A_HALT, 1'b1, 8'h01);
    check("halt_set", program_finish, 1'b1);
    bus(32'h0000_0100, 1'b0, 8'h00);
    bus(32'h0000_0100, 1'b0, 8'h00);
    check("halt_sticky", program_finish, 1'b1);

`ifdef MEM_IO_RX_EN
    rx_valid = 1'b1; rx_data = 8'h3C;
    step();
    rx_valid = 1'b0;
    bus(A_DATA, 1'b0, 8'h00);
    check("rx_pop", mem_to_mc_din, 8'h3C);
    bus(A_DATA, 1'b0, 8'h00);
    check("rx_empty_rd", mem_to_mc_din, 8'h00);
    rx_valid = 1'b1; rx_data = 8'h5A;
    step();
    rx_data = 8'h6B;
    bus(A_DATA, 1'b0, 8'h00);
    rx_valid = 1'b0;
    check("rx_same_cycle_old", mem_to_mc_din, 8'h5A);
    bus(A_DATA, 1'b0, 8'h00);
    check("rx_same_cycle_new", mem_to_mc_din, 8'h6B);
`else
    rx_valid = 1'b1; rx_data = 8'h3C;
    step();
    check("rx_ready_tied", rx_ready, 1'b0);
    bus(A_DATA, 1'b0, 8'h00);
    rx_valid = 1'b0;
    check("rx_disabled_rd", mem_to_mc_din, 8'h00);
`endif

    // Reset with bytes queued discards them.
    tx_ready = 1'b0;
    bus(A_DATA, 1'b1, 8'hD1);
    bus(A_DATA, 1'b1, 8'hD2);
    bus(A_DATA, 1'b1, 8'hD3);
    mc_to_mem_addr = 32'h0000_0100;
    mc_to_mem_wr   = 1'b0;
    check("pre_rst_txv", tx_valid, 1'b1);
    check("pre_rst_txd", tx_data,  8'hD1);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    check("rst_txv",    tx_valid,       1'b0);
    check("rst_txd",    tx_data,        8'h00);
    check("rst_finish", program_finish, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
